// File: rtl/cartoon_pkg.sv
// Shared types and constants for the 3x3 window fetch controller.
// The offset tables give the (row, col) delta of window pixel k from the centre.
package cartoon_pkg;

  localparam int unsigned PIX_W   = 24;
  localparam int unsigned WIN_N   = 9;
  localparam int unsigned WIN_W   = PIX_W * WIN_N;
  localparam int unsigned GRID_W  = 8 * WIN_N;
  localparam int unsigned COORD_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRd,
    StCompute,
    StOutput
  } state_e;

  localparam int ROW_OFF [WIN_N] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int COL_OFF [WIN_N] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/window_fetch_ctrl_if.sv
// Bundle of control, memory, intensity-unit and output handshake signals.
// master is the controller side, slave the environment side.
interface window_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 19
);
  import cartoon_pkg::*;

  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 mem_rd;
  logic [ADDR_W-1:0]    mem_addr;
  logic [PIX_W-1:0]     mem_rdata;
  logic                 mem_rvalid;
  logic [WIN_W-1:0]     pixel_data;
  logic [GRID_W-1:0]    i_grid;
  logic [GRID_W-1:0]    out_grid;
  logic [COORD_W-1:0]   out_row;
  logic [COORD_W-1:0]   out_col;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  start, abort, mem_rdata, mem_rvalid, i_grid, out_ready,
    output busy, done, mem_rd, mem_addr, pixel_data, out_grid, out_row, out_col, out_valid
  );

  modport slave (
    output start, abort, mem_rdata, mem_rvalid, i_grid, out_ready,
    input  busy, done, mem_rd, mem_addr, pixel_data, out_grid, out_row, out_col, out_valid
  );

endinterface

// File: rtl/win_addr_gen.sv
// Combinational address generator: centre + window index k -> clamped pixel address.
// Out-of-image neighbours replicate the nearest edge pixel.
module win_addr_gen
  import cartoon_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic [COORD_W-1:0] row_i,
  input  logic [COORD_W-1:0] col_i,
  input  logic [3:0]         k_i,
  output logic [ADDR_W-1:0]  addr_o
);

  int kk;
  int r;
  int c;

  always_comb begin
    kk     = (k_i > 4'd8) ? 8 : int'(k_i);
    r      = clamp(int'(row_i) + ROW_OFF[kk], int'(IMG_H) - 1);
    c      = clamp(int'(col_i) + COL_OFF[kk], int'(IMG_W) - 1);
    addr_o = ADDR_W'(r * int'(IMG_W) + c);
  end

endmodule

// File: rtl/window_fetch_ctrl.sv
// Raster-scans 3x3 windows: fetches nine pixels one read at a time, waits for the
// external intensity unit, then presents the registered intensity grid.
module window_fetch_ctrl
  import cartoon_pkg::*;
#(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned INT_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  window_fetch_ctrl_if.master bus
);

  state_e             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [2:0]         lat_q, lat_d;
  logic [WIN_W-1:0]   pix_q, pix_d;
  logic [GRID_W-1:0]  grid_q, grid_d;
  logic [COORD_W-1:0] out_row_q, out_row_d;
  logic [COORD_W-1:0] out_col_q, out_col_d;
  logic               done_q, done_d;
  logic               last_win;
  logic [ADDR_W-1:0]  addr;

  win_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .row_i  (row_q),
    .col_i  (col_q),
    .k_i    (k_q),
    .addr_o (addr)
  );

  assign last_win = (row_q == COORD_W'(IMG_H - 1)) && (col_q == COORD_W'(IMG_W - 1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    row_d     = row_q;
    col_d     = col_q;
    lat_d     = lat_q;
    pix_d     = pix_q;
    grid_d    = grid_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    done_d    = 1'b0;

    if (bus.abort && state_q != StIdle) begin
      // Abort beats every other event, including a read return or handshake.
      state_d = StIdle;
      k_d     = '0;
      row_d   = '0;
      col_d   = '0;
      lat_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            state_d = StFetch;
            k_d     = '0;
            row_d   = '0;
            col_d   = '0;
          end
        end
        StFetch: state_d = StWaitRd;
        StWaitRd: begin
          if (bus.mem_rvalid) begin
            for (int i = 0; i < int'(WIN_N); i++) begin
              if (k_q == 4'(i)) pix_d[WIN_W-1-PIX_W*i -: PIX_W] = bus.mem_rdata;
            end
            if (k_q == 4'd8) begin
              state_d = StCompute;
              lat_d   = '0;
            end else begin
              k_d     = k_q + 4'd1;
              state_d = StFetch;
            end
          end
        end
        StCompute: begin
          if (lat_q == 3'(INT_LAT - 1)) begin
            grid_d    = bus.i_grid;
            out_row_d = row_q;
            out_col_d = col_q;
            state_d   = StOutput;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        StOutput: begin
          if (bus.out_ready) begin
            k_d = '0;
            if (last_win) begin
              done_d  = 1'b1;
              row_d   = '0;
              col_d   = '0;
              state_d = StIdle;
            end else begin
              if (col_q == COORD_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_q + COORD_W'(1);
              end else begin
                col_d = col_q + COORD_W'(1);
              end
              state_d = StFetch;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      lat_q     <= '0;
      pix_q     <= '0;
      grid_q    <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lat_q     <= lat_d;
      pix_q     <= pix_d;
      grid_q    <= grid_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      done_q    <= done_d;
    end
  end

  // Centre and k only change on state transitions, so the address is stable in WAIT_RD.
  assign bus.mem_addr   = addr;
  assign bus.mem_rd     = (state_q == StFetch);
  assign bus.busy       = (state_q != StIdle);
  assign bus.out_valid  = (state_q == StOutput);
  assign bus.done       = done_q;
  assign bus.pixel_data = pix_q;
  assign bus.out_grid   = grid_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;

endmodule
